// File: rtl/crc24_attach_pkg.sv
// rtl/crc24_attach_pkg.sv - shared constants, FSM encoding and CRC24B step for crc24_attach
package crc24_attach_pkg;

    localparam int          SMALL_K  = 1056;
    localparam int          LARGE_K  = 6144;
    localparam int          CRC_LEN  = 24;
    localparam logic [23:0] CRC_POLY = 24'h800063;
    localparam int          CNT_W    = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

    // Index of the last payload bit for a block of the given size.
    function automatic logic [CNT_W-1:0] last_payload_idx(input logic blocksize);
        return blocksize ? CNT_W'(LARGE_K - CRC_LEN - 1) : CNT_W'(SMALL_K - CRC_LEN - 1);
    endfunction

    function automatic logic [CRC_LEN-1:0] crc_step(input logic [CRC_LEN-1:0] crc,
                                                    input logic              bit_in);
        logic fb;
        fb = crc[CRC_LEN-1] ^ bit_in;
        return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc24_lfsr.sv
// rtl/crc24_lfsr.sv - CRC24B register: absorbs payload bits, then shifts the remainder out MSB first
module crc24_lfsr
    import crc24_attach_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_in_en,
    input  logic               shift_out_en,
    input  logic               bit_in,
    output logic [CRC_LEN-1:0] crc
);

    logic [CRC_LEN-1:0] r_crc;
    logic [CRC_LEN-1:0] w_base;

    // clear with shift_in_en seeds the register from the first bit of a block
    assign w_base = clear ? '0 : r_crc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= '0;
        end else if (shift_in_en) begin
            r_crc <= crc_step(w_base, bit_in);
        end else if (shift_out_en) begin
            r_crc <= {r_crc[CRC_LEN-2:0], 1'b0};
        end else if (clear) begin
            r_crc <= '0;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/crc24_attach.sv
// rtl/crc24_attach.sv - serial code-block framer appending CRC24B ahead of the turbo interleaver
module crc24_attach
    import crc24_attach_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_start,
    input  logic in_blocksize,
    output logic in_ready,
    output logic data_out,
    output logic out_valid,
    output logic CRC_start,
    output logic CRC_blocksize,
    output logic CRC_end,
    output logic error
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_data;
    logic               r_valid;
    logic               r_start;
    logic               r_blocksize;
    logic               r_end;
    logic               r_error;

    logic               w_take_start;
    logic               w_take_bit;
    logic [CRC_LEN-1:0] w_crc;

    // A start bit is honoured in IDLE and, as an abort-and-restart, in DATA.
    assign w_take_start = in_valid & in_start & (r_state != ST_CRC);
    assign w_take_bit   = w_take_start | ((r_state == ST_DATA) & in_valid);

    crc24_lfsr u_lfsr (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_take_start),
        .shift_in_en  (w_take_bit),
        .shift_out_en (r_state == ST_CRC),
        .bit_in       (in_bit),
        .crc          (w_crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_data      <= 1'b0;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_blocksize <= 1'b0;
            r_end       <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_error <= 1'b0;
            if (w_take_start) begin
                r_state     <= ST_DATA;
                r_cnt       <= '0;
                r_data      <= in_bit;
                r_valid     <= 1'b1;
                r_start     <= 1'b1;
                r_blocksize <= in_blocksize;
                r_error     <= (r_state == ST_DATA);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_data  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                    ST_DATA: begin
                        if (!in_valid) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_data  <= 1'b0;
                            r_valid <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_data  <= in_bit;
                            r_valid <= 1'b1;
                            if (r_cnt + CNT_W'(1) == last_payload_idx(r_blocksize)) begin
                                r_state <= ST_CRC;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_CRC: begin
                        r_data  <= w_crc[CRC_LEN-1];
                        r_valid <= 1'b1;
                        if (r_cnt == CNT_W'(CRC_LEN - 1)) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_end   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_data  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready      = (r_state != ST_CRC);
    assign data_out      = r_data;
    assign out_valid     = r_valid;
    assign CRC_start     = r_start;
    assign CRC_blocksize = r_blocksize;
    assign CRC_end       = r_end;
    assign error         = r_error;

endmodule

// File: tb/tb_crc24_attach.sv
// tb/tb_crc24_attach.sv - self-checking bench for crc24_attach with a polynomial-division reference
module tb_crc24_attach;

    logic clk = 1'b0;
    logic reset, in_valid, in_bit, in_start, in_blocksize;
    logic in_ready, data_out, out_valid, CRC_start, CRC_blocksize, CRC_end, error;

    int checks = 0;
    int errors = 0;

    logic pl  [0:6143];
    logic cap [0:6143];

    typedef struct {
        logic v, b, s, bs;
        logic ov, d, st, er, obs;
    } vec_t;
    vec_t tbl [11];

    crc24_attach dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_bit        (in_bit),
        .in_start      (in_start),
        .in_blocksize  (in_blocksize),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .CRC_start     (CRC_start),
        .CRC_blocksize (CRC_blocksize),
        .CRC_end       (CRC_end),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Remainder of M(x)*x^24 mod G(x) by long division over the bit sequence.
    function automatic logic [23:0] poly_rem(input int n, input bit use_cap);
        logic        w [0:6167];
        logic [24:0] g;
        logic [23:0] r;
        g = 25'h1800063;
        for (int i = 0; i < n + 24; i++)
            w[i] = (i < n) ? (use_cap ? cap[i] : pl[i]) : 1'b0;
        for (int i = 0; i < n; i++)
            if (w[i])
                for (int j = 0; j < 25; j++)
                    w[i+j] = w[i+j] ^ g[24-j];
        for (int k = 0; k < 24; k++)
            r[23-k] = w[n+k];
        return r;
    endfunction

    task automatic idle_check();
        in_valid = 1'b0;
        in_start = 1'b0;
        step();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_error", error, 0);
        chk("idle_crc_end", CRC_end, 0);
    endtask

    // mode: 0 normal, 1 gap at payload bit 'at', 2 stop before bit 'at' (caller restarts),
    // 3 reset during CRC bit 'at'
    task automatic run_block(input logic bs, input int fill, input int mode, input int at,
                             input logic first_err);
        int          p;
        logic [23:0] rem;
        p = bs ? 6120 : 1032;
        for (int i = 0; i < p; i++)
            pl[i] = (fill == 0) ? 1'b0 : (fill == 1) ? (i == 0) : 1'($urandom_range(0, 1));
        rem = poly_rem(p, 1'b0);
        for (int i = 0; i < p; i++) begin
            if (mode == 1 && i == at) begin
                in_valid = 1'b0;
                in_start = 1'b0;
                step();
                chk("gap_error", error, 1);
                chk("gap_out_valid", out_valid, 0);
                chk("gap_crc_end", CRC_end, 0);
                step();
                chk("gap_error_pulse", error, 0);
                chk("gap_idle_valid", out_valid, 0);
                chk("gap_no_end", CRC_end, 0);
                return;
            end
            if (mode == 2 && i == at) return;
            in_valid     = 1'b1;
            in_bit       = pl[i];
            in_start     = (i == 0);
            in_blocksize = (i == 0) ? bs : 1'($urandom_range(0, 1));
            chk("ready_data", in_ready, 1);
            step();
            chk("data_bit", data_out, pl[i]);
            chk("data_valid", out_valid, 1);
            chk("data_start", CRC_start, (i == 0));
            chk("data_end", CRC_end, 0);
            chk("data_error", error, (i == 0) && first_err);
            chk("data_blocksize", CRC_blocksize, bs);
            cap[i] = data_out;
        end
        for (int k = 0; k < 24; k++) begin
            in_valid     = 1'($urandom_range(0, 1));
            in_start     = 1'($urandom_range(0, 1));
            in_bit       = 1'($urandom_range(0, 1));
            in_blocksize = 1'($urandom_range(0, 1));
            chk("ready_crc", in_ready, 0);
            if (mode == 3 && k == at) begin
                reset = 1'b1;
                step();
                reset    = 1'b0;
                in_valid = 1'b0;
                in_start = 1'b0;
                chk("rst_outs", {data_out, out_valid, CRC_start, CRC_blocksize, CRC_end, error}, 0);
                chk("rst_ready", in_ready, 1);
                return;
            end
            step();
            chk("crc_bit", data_out, rem[23-k]);
            chk("crc_valid", out_valid, 1);
            chk("crc_end", CRC_end, (k == 23));
            chk("crc_start", CRC_start, 0);
            chk("crc_error", error, 0);
            chk("crc_blocksize", CRC_blocksize, bs);
            cap[p+k] = data_out;
        end
        in_valid = 1'b0;
        in_start = 1'b0;
        chk("ready_after", in_ready, 1);
        chk("codeword_rem", poly_rem(p + 24, 1'b1), 0);
    endtask

    initial begin
        tbl[0]  = '{v:1, b:1, s:0, bs:0, ov:0, d:0, st:0, er:0, obs:0};
        tbl[1]  = '{v:0, b:0, s:0, bs:0, ov:0, d:0, st:0, er:0, obs:0};
        tbl[2]  = '{v:1, b:1, s:1, bs:1, ov:1, d:1, st:1, er:0, obs:1};
        tbl[3]  = '{v:1, b:0, s:0, bs:0, ov:1, d:0, st:0, er:0, obs:1};
        tbl[4]  = '{v:1, b:1, s:0, bs:0, ov:1, d:1, st:0, er:0, obs:1};
        tbl[5]  = '{v:0, b:1, s:1, bs:0, ov:0, d:0, st:0, er:1, obs:1};
        tbl[6]  = '{v:0, b:0, s:0, bs:0, ov:0, d:0, st:0, er:0, obs:1};
        tbl[7]  = '{v:1, b:0, s:1, bs:0, ov:1, d:0, st:1, er:0, obs:0};
        tbl[8]  = '{v:1, b:1, s:1, bs:1, ov:1, d:1, st:1, er:1, obs:1};
        tbl[9]  = '{v:0, b:0, s:0, bs:0, ov:0, d:0, st:0, er:1, obs:1};
        tbl[10] = '{v:0, b:0, s:0, bs:0, ov:0, d:0, st:0, er:0, obs:1};

        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_start = 1'b0; in_blocksize = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_outs", {data_out, out_valid, CRC_start, CRC_blocksize, CRC_end, error}, 0);
        chk("reset_ready", in_ready, 1);

        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].v; in_bit = tbl[i].b; in_start = tbl[i].s; in_blocksize = tbl[i].bs;
            chk("tbl_ready", in_ready, 1);
            step();
            chk("tbl_valid", out_valid, tbl[i].ov);
            chk("tbl_data", data_out, tbl[i].d);
            chk("tbl_start", CRC_start, tbl[i].st);
            chk("tbl_error", error, tbl[i].er);
            chk("tbl_blocksize", CRC_blocksize, tbl[i].obs);
            chk("tbl_end", CRC_end, 0);
        end

        run_block(1'b0, 0, 0, 0, 1'b0);     // small, all zeros
        idle_check();
        run_block(1'b0, 1, 0, 0, 1'b0);     // small, single leading one
        idle_check();
        run_block(1'b1, 2, 0, 0, 1'b0);     // large, random
        idle_check();
        run_block(1'b0, 2, 0, 0, 1'b0);     // back-to-back pair
        run_block(1'b0, 2, 0, 0, 1'b0);
        idle_check();
        run_block(1'b0, 2, 1, 500, 1'b0);   // gap at bit 500
        run_block(1'b0, 2, 0, 0, 1'b0);
        idle_check();
        run_block(1'b0, 2, 3, 10, 1'b0);    // reset during CRC bit 10
        run_block(1'b1, 2, 0, 0, 1'b0);
        idle_check();
        run_block(1'b0, 2, 2, 300, 1'b0);   // restart at bit 300
        run_block(1'b0, 2, 0, 0, 1'b1);
        idle_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
